ysyx_23060191_mcu_seq: RTL and testbench
========================================

# ysyx_23060191_mcu_seq

Multi-cycle sequencer for the next-generation RV32E/I core; the successor to the single-cycle top. Owns the PC and instruction register and steps each instruction through FETCH, EXEC, MEM and WB. Fetch and load/store traffic use req/ack handshakes, so IFU and LSU memories may take any number of cycles. Decoder, GPR and EXU stay combinational and are driven from the latched instruction.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT_CYCLES, 255, max wait cycles for an ack before a bus error (8-bit wait counter, ≥1)

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset; **synchronous, active-low**
- if_req  out  1  fetch request, held until ack
- if_addr  out  XLEN  fetch address (= pc)
- if_ack  in  1  fetch data valid
- if_rdata  in  32  fetched instruction
- ls_req / ls_we  out  1 / 1  data request / write strobe (1 = store)
- ls_addr / ls_wdata  out  XLEN / XLEN  latched exu_res / latched data_Rs2
- ls_ack / ls_rdata  in  1 / XLEN  data ack / load data (already sign/zero-extended by LSU)
- dec_wr_en_rd, dec_jal, dec_jalr, dec_branch, dec_load, dec_store, dec_ebreak  in  1 each  decoder controls
- imm, data_rs1, data_rs2, exu_res  in  XLEN  decoder/GPR/EXU values
- exu_zero  in  1  branch condition from EXU
- pc  out  XLEN  current PC
- inst  out  32  instruction register
- gpr_wen  out  1  GPR write enable (one WB cycle)
- gpr_wdata  out  XLEN  writeback data
- commit  out  1  one-cycle retire pulse
- halted / bus_err  out  1 / 1  sticky halt / sticky timeout error
- perf_cycles / perf_instret  out  64 / 64  performance counters (see Configuration)

## Operation
- States: FETCH, EXEC, MEM, WB, HALT, ERROR.
- FETCH: if_req = 1. On if_ack, inst <= if_rdata → EXEC.
- EXEC (1 cycle): latch exu_res, data_rs1, data_rs2, exu_zero and the decoder controls.
  - dec_load or dec_store → MEM.
  - Otherwise → WB.
- MEM: ls_req = 1, ls_we = store.
  - On ls_ack: load data <= ls_rdata → WB.
  - A store ignores ls_rdata.
- WB (1 cycle):
  - gpr_wen = wr_en_rd; gpr_wdata = load ? load data : exu_res.
  - commit = 1.
  - Next PC priority: jalr → (rs1 + imm) & ~1; jal → pc + imm; branch & zero → pc + imm; else pc + 4. All arithmetic mod 2^XLEN.
  - If ebreak: pc unchanged, no GPR write, commit = 1, → HALT. Otherwise → FETCH.
- HALT / ERROR: terminal; all requests 0; left only by reset.
- Handshakes:
  - An ack is accepted in any cycle its req is high, including the first cycle of the request.
  - An ack arriving while its req is low is ignored.
  - req and addr stay stable until ack.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle with no ack.
  - When it equals TIMEOUT_CYCLES without an ack: → ERROR, bus_err = 1.
- Misaligned fetch address is not checked here; the IFU owns that check.

## Timing
- Reset (rstn = 0 at an edge): pc = RESET_PC, inst = 0, state FETCH, wait counter 0, halted = 0, bus_err = 0, counters 0. All outputs except pc/if_addr are 0, including if_req.
- if_req rises the first cycle after rstn returns high.
- Reset mid-operation aborts any pending request the next cycle; no commit or GPR write occurs.
- Minimum CPI: 3 for ALU/branch/jump (ack in the same cycle as req); 4 for load/store. Each cycle of ack delay adds 1.
- gpr_wen, commit and pc update coincide in the same WB cycle; the new pc is visible the cycle after WB.

## Configuration
- YSYX_23060191_SEQ_PERF_EN defined:
  - perf_cycles increments every cycle out of reset, including HALT/ERROR.
  - perf_instret increments on each commit.
  - Both wrap mod 2^64.
- Undefined: both outputs tied to 0 and no counter flops.

## Test plan
- Reset release, addi x1,x0,5 with immediate ack → if_addr = 0x8000_0000; WB cycle gpr_wen = 1, gpr_wdata = 5; commit at cycle 3; next pc = 0x8000_0004.
- lw with exu_res = 0x8000_1000, ls_ack 2 cycles late, ls_rdata = 0xDEAD_BEEF → ls_addr held at 0x8000_1000 for 3 cycles; gpr_wdata = 0xDEAD_BEEF; CPI = 6.
- Taken beq at pc = 0x8000_0010, imm = -16, zero = 1 → pc = 0x8000_0000. jalr with rs1 = 0x8000_0101, imm = 2 → pc = 0x8000_0102.
- if_ack held low → ERROR after 255 waiting cycles; bus_err = 1 sticky; no requests until reset.
- ebreak → commit pulse, no GPR write, halted = 1; if_req stays 0. A later stray if_ack is ignored.
- With PERF_EN: 10 ALU instructions with zero-latency acks → perf_instret = 10, perf_cycles ≥ 30. Reset mid-MEM → no commit, counters 0.

Source files
------------

// File: rtl/ysyx_23060191_mcu_seq.sv
// ysyx_23060191_mcu_seq: multi-cycle FETCH/EXEC/MEM/WB sequencer with req/ack buses; perf counters under YSYX_23060191_SEQ_PERF_EN
module ysyx_23060191_mcu_seq #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            if_req,
  output logic [XLEN-1:0] if_addr,
  input  logic            if_ack,
  input  logic [31:0]     if_rdata,
  output logic            ls_req,
  output logic            ls_we,
  output logic [XLEN-1:0] ls_addr,
  output logic [XLEN-1:0] ls_wdata,
  input  logic            ls_ack,
  input  logic [XLEN-1:0] ls_rdata,
  input  logic            dec_wr_en_rd,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic            dec_branch,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_ebreak,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  input  logic [XLEN-1:0] exu_res,
  input  logic            exu_zero,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            gpr_wen,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            commit,
  output logic            halted,
  output logic            bus_err,
  output logic [63:0]     perf_cycles,
  output logic [63:0]     perf_instret
);
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
  logic [2:0] state, state_n;
  logic run;
  logic [7:0] wcnt;
  logic [XLEN-1:0] res_q, rs1_q, rs2_q, imm_q, ldata_q, npc;
  logic zero_q, wr_q, jal_q, jalr_q, br_q, ld_q, st_q, eb_q;
  logic if_ok, ls_ok, tmo, wb;
  // run holds off the first fetch until the cycle after reset is released
  assign if_req = run && state == S_FETCH;
  assign ls_req = state == S_MEM;
  assign ls_we = ls_req & st_q;
  assign if_addr = pc;
  assign ls_addr = res_q;
  assign ls_wdata = rs2_q;
  assign if_ok = if_req & if_ack;
  assign ls_ok = ls_req & ls_ack;
  assign tmo = (if_req | ls_req) & ~(if_ok | ls_ok) & (wcnt == 8'(TIMEOUT_CYCLES - 1));
  assign wb = state == S_WB;
  assign commit = wb;
  assign gpr_wen = wb & wr_q & ~eb_q;
  assign gpr_wdata = ld_q ? ldata_q : res_q;
  assign halted = state == S_HALT;
  assign bus_err = state == S_ERROR;
  assign npc = eb_q ? pc
             : jalr_q ? (rs1_q + imm_q) & ~XLEN'(1)
             : (jal_q | (br_q & zero_q)) ? pc + imm_q
             : pc + XLEN'(4);
  // next state: an accepted ack wins over a timeout in the same cycle
  always_comb begin
    state_n = if_ok ? S_EXEC
            : ls_ok ? S_WB
            : tmo ? S_ERROR
            : state == S_EXEC ? ((dec_load | dec_store) ? S_MEM : S_WB)
            : wb ? (eb_q ? S_HALT : S_FETCH)
            : state;
  end
  // sequencer state, instruction register, EXEC operand latches and PC update
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_FETCH;
      run <= 1'b0;
      wcnt <= 8'd0;
      pc <= RESET_PC;
      inst <= 32'd0;
      res_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      ldata_q <= '0;
      {zero_q, wr_q, jal_q, jalr_q, br_q, ld_q, st_q, eb_q} <= 8'd0;
    end else begin
      run <= 1'b1;
      state <= state_n;
      wcnt <= (state_n != state) ? 8'd0 : wcnt + {7'd0, if_req | ls_req};
      if (if_ok) inst <= if_rdata;
      if (state == S_EXEC) begin
        res_q <= exu_res;
        rs1_q <= data_rs1;
        rs2_q <= data_rs2;
        imm_q <= imm;
        {zero_q, wr_q, jal_q, jalr_q, br_q, ld_q, st_q, eb_q} <=
          {exu_zero, dec_wr_en_rd, dec_jal, dec_jalr, dec_branch, dec_load, dec_store, dec_ebreak};
      end
      if (ls_ok) ldata_q <= ls_rdata;
      if (wb) pc <= npc;
    end
  end
`ifdef YSYX_23060191_SEQ_PERF_EN
  logic [63:0] cyc_q, ret_q;
  // free-running cycle and retired-instruction counters, wrapping mod 2^64
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cyc_q <= 64'd0;
      ret_q <= 64'd0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      if (commit) ret_q <= ret_q + 64'd1;
    end
  end
  assign perf_cycles = cyc_q;
  assign perf_instret = ret_q;
`else
  assign perf_cycles = 64'd0;
  assign perf_instret = 64'd0;
`endif
endmodule

// File: tb/tb_ysyx_23060191_mcu_seq.sv
// tb_ysyx_23060191_mcu_seq: table-driven and randomized checks of the sequencer against a behavioural model
`timescale 1ns/1ps
module tb_ysyx_23060191_mcu_seq;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic clk = 1'b0, rstn = 1'b0;
  logic if_req, if_ack = 1'b0, ls_req, ls_we, ls_ack = 1'b0;
  logic [31:0] if_addr, if_rdata = 32'd0, ls_addr, ls_wdata, ls_rdata = 32'd0;
  logic dec_wr_en_rd = 1'b0, dec_jal = 1'b0, dec_jalr = 1'b0, dec_branch = 1'b0;
  logic dec_load = 1'b0, dec_store = 1'b0, dec_ebreak = 1'b0, exu_zero = 1'b0;
  logic [31:0] imm = 32'd0, data_rs1 = 32'd0, data_rs2 = 32'd0, exu_res = 32'd0;
  logic [31:0] pc, inst, gpr_wdata;
  logic gpr_wen, commit, halted, bus_err;
  logic [63:0] perf_cycles, perf_instret;

  always #5 clk = ~clk;

  ysyx_23060191_mcu_seq dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .dec_wr_en_rd(dec_wr_en_rd), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
    .dec_branch(dec_branch), .dec_load(dec_load), .dec_store(dec_store),
    .dec_ebreak(dec_ebreak), .imm(imm), .data_rs1(data_rs1), .data_rs2(data_rs2),
    .exu_res(exu_res), .exu_zero(exu_zero), .pc(pc), .inst(inst),
    .gpr_wen(gpr_wen), .gpr_wdata(gpr_wdata), .commit(commit), .halted(halted),
    .bus_err(bus_err), .perf_cycles(perf_cycles), .perf_instret(perf_instret)
  );

  // ctl = {wr, jal, jalr, branch, load, store, ebreak}
  typedef struct {
    logic [6:0] ctl;
    logic zero;
    logic [31:0] inst, imm, rs1, rs2, res, rdata;
    int if_dly, ls_dly;
  } vec_t;
  typedef struct {
    logic wen;
    logic [31:0] wdata;
    int cpi;
    logic [31:0] npc;
  } exp_t;
  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  int errs = 0, checks = 0, ref_ret = 0, first_req_it = 0;
  logic [31:0] mpc = RST_PC;
  logic [63:0] ref_cyc;
  rec_t tbl[11];

  always @(posedge clk) ref_cyc <= !rstn ? 64'd0 : ref_cyc + 64'd1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input vec_t v, input logic [31:0] cur);
    exp_t e;
    e.wen = v.ctl[6] && !v.ctl[0];
    e.wdata = v.ctl[2] ? v.rdata : v.res;
    e.cpi = 3 + v.if_dly + ((v.ctl[2] || v.ctl[1]) ? 1 + v.ls_dly : 0);
    if (v.ctl[0]) e.npc = cur;
    else if (v.ctl[4]) e.npc = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
    else if (v.ctl[5] || (v.ctl[3] && v.zero)) e.npc = cur + v.imm;
    else e.npc = cur + 32'd4;
    return e;
  endfunction

  task automatic run(input string nm, input vec_t v, input exp_t e);
    int it = 0, cyc = 0, fw = 0, mw = 0;
    bit done = 0;
    {dec_wr_en_rd, dec_jal, dec_jalr, dec_branch, dec_load, dec_store, dec_ebreak} = v.ctl;
    exu_zero = v.zero; imm = v.imm; data_rs1 = v.rs1; data_rs2 = v.rs2; exu_res = v.res;
    while (!done && it < e.cpi + 20) begin
      @(negedge clk);
      it++;
      if_ack = 1'b0;
      ls_ack = 1'b0;
      if (if_req || cyc > 0) cyc++;
      if (if_req) begin
        if (fw == 0) begin
          first_req_it = it;
          chk({nm, " if_addr"}, 64'(if_addr), 64'(mpc));
        end
        if (fw == v.if_dly) begin
          if_ack = 1'b1;
          if_rdata = v.inst;
        end
        fw++;
      end
      if (ls_req) begin
        chk({nm, " ls_addr"}, 64'(ls_addr), 64'(v.res));
        chk({nm, " ls_we"}, 64'(ls_we), 64'(v.ctl[1]));
        if (v.ctl[1]) chk({nm, " ls_wdata"}, 64'(ls_wdata), 64'(v.rs2));
        if (mw == v.ls_dly) begin
          ls_ack = 1'b1;
          ls_rdata = v.rdata;
        end
        mw++;
      end
      if (commit) begin
        done = 1;
        chk({nm, " gpr_wen"}, 64'(gpr_wen), 64'(e.wen));
        if (e.wen) chk({nm, " gpr_wdata"}, 64'(gpr_wdata), 64'(e.wdata));
        chk({nm, " inst"}, 64'(inst), 64'(v.inst));
        chk({nm, " cpi"}, 64'(cyc), 64'(e.cpi));
        chk({nm, " mem cycles"}, 64'(mw), 64'((v.ctl[2] || v.ctl[1]) ? v.ls_dly + 1 : 0));
      end
    end
    if (!done) chk({nm, " commit timeout"}, 64'd0, 64'd1);
    ref_ret++;
    mpc = e.npc;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rstn = 1'b0;
    if_ack = 1'b0;
    ls_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    rstn = 1'b1;
    mpc = RST_PC;
    ref_ret = 0;
  endtask

  task automatic perf_check(input string nm);
`ifdef YSYX_23060191_SEQ_PERF_EN
    chk({nm, " perf_instret"}, perf_instret, 64'(ref_ret));
    chk({nm, " perf_cycles"}, perf_cycles, ref_cyc);
`else
    chk({nm, " perf_instret"}, perf_instret, 64'd0);
    chk({nm, " perf_cycles"}, perf_cycles, 64'd0);
`endif
  endtask

  initial begin
    vec_t v;
    int n, t;
    tbl[0]  = '{'{7'b1000000, 1'b0, 32'h00500093, 32'd5, 32'd0, 32'd0, 32'd5, 32'd0, 0, 0}, '{1'b1, 32'd5, 3, 32'h8000_0004}};
    tbl[1]  = '{'{7'b1000100, 1'b0, 32'h0000A083, 32'd0, 32'd0, 32'd0, 32'h8000_1000, 32'hDEAD_BEEF, 0, 2}, '{1'b1, 32'hDEAD_BEEF, 6, 32'h8000_0008}};
    tbl[2]  = '{'{7'b0000010, 1'b0, 32'h0020A223, 32'd4, 32'h8000_1000, 32'h1234_5678, 32'h8000_1004, 32'hFFFF_FFFF, 1, 0}, '{1'b0, 32'd0, 5, 32'h8000_000C}};
    tbl[3]  = '{'{7'b1100000, 1'b0, 32'h004000EF, 32'd4, 32'd0, 32'd0, 32'h8000_0010, 32'd0, 0, 0}, '{1'b1, 32'h8000_0010, 3, 32'h8000_0010}};
    tbl[4]  = '{'{7'b0001000, 1'b1, 32'hFE0008E3, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0}, '{1'b0, 32'd0, 3, 32'h8000_0000}};
    tbl[5]  = '{'{7'b0001000, 1'b0, 32'hFE0008E3, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd1, 32'd0, 2, 0}, '{1'b0, 32'd0, 5, 32'h8000_0004}};
    tbl[6]  = '{'{7'b1010000, 1'b0, 32'h002080E7, 32'd2, 32'h8000_0101, 32'd0, 32'h8000_0008, 32'd0, 3, 0}, '{1'b1, 32'h8000_0008, 6, 32'h8000_0102}};
    tbl[7]  = '{'{7'b1000000, 1'b0, 32'h00700093, 32'd7, 32'd0, 32'd0, 32'd7, 32'd0, 254, 0}, '{1'b1, 32'd7, 257, 32'h8000_0106}};
    tbl[8]  = '{'{7'b1000100, 1'b0, 32'h0100C083, 32'h10, 32'd0, 32'd0, 32'h10, 32'h0000_00FF, 0, 254}, '{1'b1, 32'h0000_00FF, 258, 32'h8000_010A}};
    tbl[9]  = '{'{7'b0111000, 1'b1, 32'h01108067, 32'h11, 32'h0000_1000, 32'd0, 32'd0, 32'd0, 0, 0}, '{1'b0, 32'd0, 3, 32'h0000_1010}};
    tbl[10] = '{'{7'b0000000, 1'b0, 32'h00000013, 32'd0, 32'd0, 32'd0, 32'h55, 32'd0, 0, 0}, '{1'b0, 32'd0, 3, 32'h0000_1014}};

    hold_reset();
    chk("rst pc", 64'(pc), 64'(RST_PC));
    chk("rst inst", 64'(inst), 64'd0);
    chk("rst ctl outs", 64'({if_req, ls_req, ls_we, commit, gpr_wen, halted, bus_err}), 64'd0);
    chk("rst ls_addr", 64'(ls_addr), 64'd0);
    chk("rst perf", perf_cycles | perf_instret, 64'd0);
    release_reset();

    for (int i = 0; i < 11; i++) begin
      run($sformatf("vec%0d", i), tbl[i].v, tbl[i].e);
      if (i == 0) chk("if_req first cycle after release", 64'(first_req_it), 64'd1);
    end

    for (int k = 0; k < 40; k++) begin
      t = $urandom_range(0, 5);
      v.ctl = {1'($urandom_range(0, 1)), 6'd0};
      v.zero = 1'($urandom_range(0, 1));
      v.inst = $urandom; v.imm = $urandom; v.rs1 = $urandom;
      v.rs2 = $urandom; v.res = $urandom; v.rdata = $urandom;
      v.if_dly = $urandom_range(0, 3);
      v.ls_dly = $urandom_range(0, 3);
      if (t > 0) v.ctl[6 - t] = 1'b1;
      if (t == 2) v.ctl[6] = 1'b0;
      run($sformatf("rnd%0d", k), v, model(v, mpc));
    end

    v = '{7'b1000001, 1'b0, 32'h00100073, 32'd8, 32'd0, 32'd0, 32'h77, 32'd0, 1, 0};
    run("ebreak", v, model(v, mpc));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_ack = 1'b1;
      ls_ack = 1'b1;
      chk("halt quiet", 64'({if_req, ls_req, commit, gpr_wen, halted}), 64'd1);
      chk("halt pc", 64'(pc), 64'(mpc));
    end
    if_ack = 1'b0;
    ls_ack = 1'b0;
    perf_check("after halt");

    hold_reset();
    release_reset();
    n = 0;
    for (int i = 0; i < 400 && !bus_err; i++) begin
      @(negedge clk);
      if (if_req) n++;
    end
    chk("fetch timeout req cycles", 64'(n), 64'd255);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_ack = 1'b1;
      chk("fetch err quiet", 64'({if_req, ls_req, commit, bus_err}), 64'd1);
    end
    if_ack = 1'b0;

    hold_reset();
    release_reset();
    {dec_wr_en_rd, dec_jal, dec_jalr, dec_branch, dec_load, dec_store, dec_ebreak} = 7'b1000100;
    exu_res = 32'h8000_2000;
    n = 0;
    for (int i = 0; i < 600 && !bus_err; i++) begin
      @(negedge clk);
      if_ack = if_req;
      if (ls_req) n++;
    end
    if_ack = 1'b0;
    chk("mem timeout req cycles", 64'(n), 64'd255);
    @(negedge clk);
    chk("mem err quiet", 64'({if_req, ls_req, commit, bus_err}), 64'd1);

    hold_reset();
    release_reset();
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if_ack = if_req;
      if (ls_req) n++;
    end
    if_ack = 1'b0;
    chk("reached mem", 64'(n), 64'd2);
    rstn = 1'b0;
    ls_ack = 1'b1;
    @(negedge clk);
    chk("mid-mem reset outs", 64'({if_req, ls_req, commit, gpr_wen, bus_err}), 64'd0);
    chk("mid-mem reset pc", 64'(pc), 64'(RST_PC));
    chk("mid-mem reset perf", perf_cycles | perf_instret, 64'd0);
    ls_ack = 1'b0;
    release_reset();

    for (int k = 0; k < 10; k++) begin
      v = '{7'b1000000, 1'b0, 32'h00000093, 32'(k), 32'd0, 32'd0, $urandom, 32'd0, 0, 0};
      run($sformatf("alu%0d", k), v, model(v, mpc));
    end
    @(negedge clk);
    perf_check("ten alu");
`ifdef YSYX_23060191_SEQ_PERF_EN
    chk("ten alu instret", perf_instret, 64'd10);
    chk("ten alu cycles>=30", 64'(perf_cycles >= 64'd30), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
